registro_universal: RTL and testbench
=====================================

# registro_universal

Parametrised universal register, the successor to the team's plain N-bit parallel register. It adds a clock, synchronous reset, mode-selected parallel load, logical and arithmetic shifts, rotates and clear, with serial in/out. A shift counter and an empty flag let it act as a serialiser or deserialiser. It sits between datapath blocks as a general storage/serialisation stage in the lab designs.

## Interface
- `N`, 8: data width in bits; legal range is N ≥ 2.
- `CW`, $clog2(N+1): width of the shift counter. Derived; must not be overridden.

- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `enable`  input  1: when 0 the register holds; when 1 `modo` is executed.
- `modo`  input  3: operation select (see Operation).
- `data`  input  N: parallel load value.
- `serie_in`  input  1: serial bit inserted by logical shifts.
- `salida`  output  N: register contents.
- `serie_out`  output  1: last bit shifted or rotated out.
- `cuenta`  output  CW: logical shifts since the last load, saturating at N.
- `vacio`  output  1: 1 when no loaded data remains (cuenta == N, or after clear/reset).

## Operation
- Reset (`rst_n`=0 at an edge): `salida`=0, `serie_out`=0, `cuenta`=0, `vacio`=1. Reset overrides `enable`/`modo`.
- `enable`=0: all outputs hold, regardless of `modo`.
- With `enable`=1, `modo` selects the operation:
  - 000 HOLD: no change.
  - 001 LOAD: `salida`=`data`, `cuenta`=0, `vacio`=0; `serie_out` unchanged.
  - 010 SHL: `salida`={salida[N-2:0], serie_in}; `serie_out`=old salida[N-1].
  - 011 SHR: `salida`={serie_in, salida[N-1:1]}; `serie_out`=old salida[0].
  - 100 ASHR: `salida`={salida[N-1], salida[N-1:1]}; `serie_out`=old salida[0]; `serie_in` ignored.
  - 101 ROTL: `salida`={salida[N-2:0], salida[N-1]}; `serie_out`=old salida[N-1].
  - 110 ROTR: `salida`={salida[0], salida[N-1:1]}; `serie_out`=old salida[0].
  - 111 CLR: `salida`=0, `cuenta`=0, `vacio`=1; `serie_out` unchanged.
- Counter rules:
  - SHL, SHR and ASHR increment `cuenta`, saturating at N.
  - `vacio` rises in the same cycle that `cuenta` reaches N.
  - Shifts continue to operate on `salida` after saturation; `cuenta` stays at N.
  - Rotates and HOLD leave `cuenta`/`vacio` unchanged.
- Counter width: `cuenta` is unsigned, CW bits. The N+1 values 0..N must all be representable.

## Timing
- Single-cycle latency: every operation is visible on the outputs the cycle after the edge at which it is sampled.
- All outputs are registered; there is no combinational input-to-output path.
- Simultaneous events:
  - Reset beats everything.
  - LOAD while `vacio`=1 clears `vacio` at that edge.
  - A shift at `cuenta`=N-1 sets `cuenta`=N and `vacio`=1 at the same edge.
- Reset mid-serialisation: the next cycle shows the reset values, and the partial shift is discarded.
- Changes to `modo`, `data` or `serie_in` between edges have no effect.

## Configuration
- Macro: `REGISTRO_UNIVERSAL_ROTATE_EN`.
- Defined: modes 101/110 rotate as specified.
- Undefined:
  - Rotate logic is not synthesised.
  - Codes 101/110 behave as HOLD, with all outputs unchanged.
  - All other modes are identical to the defined case.

## Test plan
- Reset and hold (N=8):
  - Apply `rst_n`=0 for 1 cycle → `salida`=0x00, `serie_out`=0, `cuenta`=0, `vacio`=1.
  - Then `enable`=0 with `modo`=001 and `data`=0xAF → outputs unchanged.
- Load and serialise:
  - LOAD 0xAF.
  - Then 8× SHR with `serie_in`=0 → `serie_out` sequence 1,1,1,1,0,1,0,1.
  - End state: `salida`=0x00, `cuenta`=8, `vacio`=1 exactly after the 8th shift.
  - A 9th shift → `cuenta` stays 8.
- Deserialise:
  - CLR, then LOAD 0x00.
  - Then 8× SHL with `serie_in`=1,0,0,0,1,1,0,0 → `salida`=0x8C, `cuenta`=8.
- Arithmetic shift and rotate:
  - LOAD 0x80, then ASHR → 0xC0, `serie_out`=0.
  - ROTL → 0x81, `serie_out`=1, `cuenta` still 1.
  - ROTR → 0xC0.
  - Without the macro, the ROTL step leaves `salida`=0xC0.
- Simultaneous and abort cases:
  - LOAD 0xFF, 3× SHL, then LOAD 0x10 → `cuenta`=0, `vacio`=0.
  - 2× SHR, then `rst_n`=0 together with `modo`=001 → all outputs at reset values.

Source files
------------

// File: rtl/registro_universal.sv
// registro_universal: N-bit universal register with parallel load, logical and
// arithmetic shifts, optional rotates and clear, plus serial in/out and a
// saturating shift counter with an empty flag for serialiser/deserialiser use.
// Optional feature macro: REGISTRO_UNIVERSAL_ROTATE_EN enables modes 101/110
// (ROTL/ROTR); without it those codes behave as HOLD and no rotate logic exists.
module registro_universal #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [2:0]    modo,
    input  logic [N-1:0]  data,
    input  logic          serie_in,
    output logic [N-1:0]  salida,
    output logic          serie_out,
    output logic [CW-1:0] cuenta,
    output logic          vacio
);

    localparam logic [2:0] MODO_HOLD = 3'b000;
    localparam logic [2:0] MODO_LOAD = 3'b001;
    localparam logic [2:0] MODO_SHL  = 3'b010;
    localparam logic [2:0] MODO_SHR  = 3'b011;
    localparam logic [2:0] MODO_ASHR = 3'b100;
`ifdef REGISTRO_UNIVERSAL_ROTATE_EN
    localparam logic [2:0] MODO_ROTL = 3'b101;
    localparam logic [2:0] MODO_ROTR = 3'b110;
`endif
    localparam logic [2:0] MODO_CLR  = 3'b111;

    // Counter value meaning "all loaded bits have been shifted out".
    localparam logic [CW-1:0] CUENTA_LLENA = CW'(N);

    logic [N-1:0]  salida_q,    salida_d;
    logic          serie_out_q, serie_out_d;
    logic [CW-1:0] cuenta_q,    cuenta_d;
    logic          vacio_q,     vacio_d;

    // Saturating increment shared by the three counting shifts.
    logic [CW-1:0] cuenta_inc;
    assign cuenta_inc = (cuenta_q == CUENTA_LLENA) ? cuenta_q : cuenta_q + CW'(1);

    // Next-state selection; defaults hold every register.
    always_comb begin
        salida_d    = salida_q;
        serie_out_d = serie_out_q;
        cuenta_d    = cuenta_q;
        vacio_d     = vacio_q;
        if (enable) begin
            case (modo)
                MODO_HOLD: begin
                end
                MODO_LOAD: begin
                    salida_d = data;
                    cuenta_d = '0;
                    vacio_d  = 1'b0;
                end
                MODO_SHL: begin
                    salida_d    = {salida_q[N-2:0], serie_in};
                    serie_out_d = salida_q[N-1];
                    cuenta_d    = cuenta_inc;
                    vacio_d     = (cuenta_inc == CUENTA_LLENA);
                end
                MODO_SHR: begin
                    salida_d    = {serie_in, salida_q[N-1:1]};
                    serie_out_d = salida_q[0];
                    cuenta_d    = cuenta_inc;
                    vacio_d     = (cuenta_inc == CUENTA_LLENA);
                end
                MODO_ASHR: begin
                    salida_d    = {salida_q[N-1], salida_q[N-1:1]};
                    serie_out_d = salida_q[0];
                    cuenta_d    = cuenta_inc;
                    vacio_d     = (cuenta_inc == CUENTA_LLENA);
                end
`ifdef REGISTRO_UNIVERSAL_ROTATE_EN
                // Rotates move bits but never count as serialisation progress.
                MODO_ROTL: begin
                    salida_d    = {salida_q[N-2:0], salida_q[N-1]};
                    serie_out_d = salida_q[N-1];
                end
                MODO_ROTR: begin
                    salida_d    = {salida_q[0], salida_q[N-1:1]};
                    serie_out_d = salida_q[0];
                end
`endif
                MODO_CLR: begin
                    salida_d = '0;
                    cuenta_d = '0;
                    vacio_d  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset that overrides all modes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            salida_q    <= '0;
            serie_out_q <= 1'b0;
            cuenta_q    <= '0;
            vacio_q     <= 1'b1;
        end else begin
            salida_q    <= salida_d;
            serie_out_q <= serie_out_d;
            cuenta_q    <= cuenta_d;
            vacio_q     <= vacio_d;
        end
    end

    assign salida    = salida_q;
    assign serie_out = serie_out_q;
    assign cuenta    = cuenta_q;
    assign vacio     = vacio_q;

endmodule

// File: tb/tb_registro_universal.sv
// Scoreboard bench for registro_universal (N=8). Each directed transaction
// pushes its hand-computed result into a queue; an independent monitor pops
// and compares one entry per issued transaction, one printed line each.
// Rotate expectations follow REGISTRO_UNIVERSAL_ROTATE_EN.
module tb_registro_universal;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [2:0]    modo;
    logic [N-1:0]  data;
    logic          serie_in;
    logic [N-1:0]  salida;
    logic          serie_out;
    logic [CW-1:0] cuenta;
    logic          vacio;

    registro_universal #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .modo      (modo),
        .data      (data),
        .serie_in  (serie_in),
        .salida    (salida),
        .serie_out (serie_out),
        .cuenta    (cuenta),
        .vacio     (vacio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [N-1:0]  salida;
        logic          serie_out;
        logic [CW-1:0] cuenta;
        logic          vacio;
    } exp_t;

    exp_t exp_q[$];
    logic txn_valid;
    int   total;
    int   bad;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ASHR = 3'b100;
    localparam logic [2:0] M_ROTL = 3'b101;
    localparam logic [2:0] M_ROTR = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    // Drive one transaction on the falling edge and record its expected result.
    task automatic op(input string name, input logic r, input logic en,
                      input logic [2:0] m, input logic [N-1:0] d, input logic si,
                      input logic [N-1:0] e_sal, input logic e_so,
                      input int e_cnt, input logic e_vac);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        enable    = en;
        modo      = m;
        data      = d;
        serie_in  = si;
        txn_valid = 1'b1;
        e.name      = name;
        e.salida    = e_sal;
        e.serie_out = e_so;
        e.cuenta    = CW'(e_cnt);
        e.vacio     = e_vac;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge that sampled a transaction yields one checked result.
    initial begin
        forever begin
            @(posedge clk);
            if (txn_valid) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: DUT output with no expected entry");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    total++;
                    if (salida !== e.salida || serie_out !== e.serie_out ||
                        cuenta !== e.cuenta || vacio !== e.vacio) begin
                        bad++;
                        $display("FAIL %s: got salida=%h so=%b cuenta=%0d vacio=%b, need salida=%h so=%b cuenta=%0d vacio=%b",
                                 e.name, salida, serie_out, cuenta, vacio,
                                 e.salida, e.serie_out, e.cuenta, e.vacio);
                    end else begin
                        $display("ok   %s: salida=%h so=%b cuenta=%0d vacio=%b",
                                 e.name, salida, serie_out, cuenta, vacio);
                    end
                end
            end
        end
    end

    // serie_out left behind by the rotate section, which differs per build.
`ifdef REGISTRO_UNIVERSAL_ROTATE_EN
    localparam logic SO_ROT = 1'b1;
`else
    localparam logic SO_ROT = 1'b0;
`endif

    initial begin
        logic [7:0] shr_exp [8];
        logic       shr_so  [8];
        logic [7:0] shl_exp [8];
        logic       shl_in  [8];
        total     = 0;
        bad       = 0;
        txn_valid = 1'b0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        modo      = M_HOLD;
        data      = '0;
        serie_in  = 1'b0;

        shr_exp = '{8'h57, 8'h2B, 8'h15, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        shr_so  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        shl_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h46, 8'h8C};
        shl_in  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset and hold
        op("reset",       1'b0, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b1);
        op("hold_en0",    1'b1, 1'b0, M_LOAD, 8'hAF, 1'b0, 8'h00, 1'b0, 0, 1'b1);

        // Load and serialise
        op("load_af",     1'b1, 1'b1, M_LOAD, 8'hAF, 1'b0, 8'hAF, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++)
            op($sformatf("shr_%0d", i + 1), 1'b1, 1'b1, M_SHR, 8'h00, 1'b0,
               shr_exp[i], shr_so[i], i + 1, (i == 7));
        op("shr_sat",     1'b1, 1'b1, M_SHR,  8'h00, 1'b0, 8'h00, 1'b0, 8, 1'b1);

        // Deserialise
        op("clr",         1'b1, 1'b1, M_CLR,  8'hFF, 1'b1, 8'h00, 1'b0, 0, 1'b1);
        op("load_00",     1'b1, 1'b1, M_LOAD, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++)
            op($sformatf("shl_%0d", i + 1), 1'b1, 1'b1, M_SHL, 8'h00, shl_in[i],
               shl_exp[i], 1'b0, i + 1, (i == 7));

        // Arithmetic shift and rotate
        op("load_80",     1'b1, 1'b1, M_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, 0, 1'b0);
        op("ashr",        1'b1, 1'b1, M_ASHR, 8'h00, 1'b1, 8'hC0, 1'b0, 1, 1'b0);
`ifdef REGISTRO_UNIVERSAL_ROTATE_EN
        op("rotl",        1'b1, 1'b1, M_ROTL, 8'h00, 1'b0, 8'h81, 1'b1, 1, 1'b0);
        op("rotr",        1'b1, 1'b1, M_ROTR, 8'h00, 1'b0, 8'hC0, 1'b1, 1, 1'b0);
`else
        op("rotl_off",    1'b1, 1'b1, M_ROTL, 8'h00, 1'b0, 8'hC0, 1'b0, 1, 1'b0);
        op("rotr_off",    1'b1, 1'b1, M_ROTR, 8'h00, 1'b0, 8'hC0, 1'b0, 1, 1'b0);
`endif

        // Load restarts count mid-serialisation
        op("load_ff",     1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0, 8'hFF, SO_ROT, 0, 1'b0);
        op("shl_a",       1'b1, 1'b1, M_SHL,  8'h00, 1'b0, 8'hFE, 1'b1, 1, 1'b0);
        op("shl_b",       1'b1, 1'b1, M_SHL,  8'h00, 1'b0, 8'hFC, 1'b1, 2, 1'b0);
        op("shl_c",       1'b1, 1'b1, M_SHL,  8'h00, 1'b0, 8'hF8, 1'b1, 3, 1'b0);
        op("load_10",     1'b1, 1'b1, M_LOAD, 8'h10, 1'b0, 8'h10, 1'b1, 0, 1'b0);

        // Extra: HOLD with enable, ASHR ignoring serie_in, SHR with serie_in=1
        op("hold_en1",    1'b1, 1'b1, M_HOLD, 8'hAA, 1'b1, 8'h10, 1'b1, 0, 1'b0);
        op("load_3c",     1'b1, 1'b1, M_LOAD, 8'h3C, 1'b0, 8'h3C, 1'b1, 0, 1'b0);
        op("ashr_sin1",   1'b1, 1'b1, M_ASHR, 8'h00, 1'b1, 8'h1E, 1'b0, 1, 1'b0);
        op("shr_sin1",    1'b1, 1'b1, M_SHR,  8'h00, 1'b1, 8'h8F, 1'b0, 2, 1'b0);
`ifdef REGISTRO_UNIVERSAL_ROTATE_EN
        op("rotl_8f",     1'b1, 1'b1, M_ROTL, 8'h00, 1'b0, 8'h1F, 1'b1, 2, 1'b0);
`else
        op("rotl_8f_off", 1'b1, 1'b1, M_ROTL, 8'h00, 1'b0, 8'h8F, 1'b0, 2, 1'b0);
`endif

        // Abort: reset beats a simultaneous load
        op("reload_10",   1'b1, 1'b1, M_LOAD, 8'h10, 1'b0, 8'h10, SO_ROT, 0, 1'b0);
        op("shr_x1",      1'b1, 1'b1, M_SHR,  8'h00, 1'b0, 8'h08, 1'b0, 1, 1'b0);
        op("shr_x2",      1'b1, 1'b1, M_SHR,  8'h00, 1'b0, 8'h04, 1'b0, 2, 1'b0);
        op("rst_vs_load", 1'b0, 1'b1, M_LOAD, 8'hAA, 1'b1, 8'h00, 1'b0, 0, 1'b1);

        @(negedge clk);
        txn_valid = 1'b0;
        enable    = 1'b0;
        rst_n     = 1'b1;

        // Bounded drain of the scoreboard.
        for (int c = 0; c < 20 && exp_q.size() != 0; c++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
